// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM: register offsets, CTRL bit
// positions, register reset values and the per-channel control record.
package pwm_multi_pkg;

  localparam logic [2:0] REG_MAX  = 3'd0;
  localparam logic [2:0] REG_THR  = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_INV     = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_PSC_LO  = 8;
  localparam int CTRL_PSC_HI  = 15;

  localparam logic [15:0] MAX_RST = 16'hFFFF;
  localparam logic [15:0] THR_RST = 16'h8000;

  typedef struct packed {
    logic [7:0] psc;
    logic       oneshot;
    logic       inv;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/pwm_multi_if.sv
// CPU I/O bus slice seen by the PWM block: chip select, write strobe,
// byte address, write data and combinational readback.
interface pwm_multi_if #(
  parameter int ADDR_W = 5
) ();
  logic              pwmCtrl;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [15:0]       write_data_in;
  logic [15:0]       read_data_out;

  modport master (
    output pwmCtrl, write_enable, address, write_data_in,
    input  read_data_out
  );

  modport slave (
    input  pwmCtrl, write_enable, address, write_data_in,
    output read_data_out
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// One PWM channel: shadow/active period and compare, prescaler, counter,
// one-shot handling, registered output and register readback.
module pwm_multi_channel
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr,
  input  logic [2:0]  offset,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        pwm,
  output logic        pend
);

  typedef logic [WIDTH-1:0] word_t;

  word_t      max_sh, thr_sh, max_act, thr_act, cnt;
  word_t      max_sh_n, thr_sh_n, max_act_n, thr_act_n, cnt_n;
  logic [7:0] pre, pre_n;
  ctrl_t      ctrl, ctrl_n;
  logic       done, done_n;
  logic       tick, wrap, pwm_n;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[CTRL_PSC_LO-1:CTRL_ONESHOT+1];
  assign tick = ctrl.en && (pre == ctrl.psc);
  assign wrap = tick && (cnt == max_act);

  // NOTE: next-state logic is combinational with blocking assignments and a
  // default for every variable first, so no latch can be inferred.
  always_comb begin
    max_sh_n  = max_sh;
    thr_sh_n  = thr_sh;
    max_act_n = max_act;
    thr_act_n = thr_act;
    cnt_n     = cnt;
    pre_n     = pre;
    ctrl_n    = ctrl;
    done_n    = done;

    if (ctrl.en) begin
      if (tick) begin
        pre_n = '0;
        if (wrap) begin
          cnt_n     = '0;
          max_act_n = max_sh;
          thr_act_n = thr_sh;
          if (ctrl.oneshot) begin
            ctrl_n.en = 1'b0;
            done_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end else begin
        pre_n = pre + 1'b1;
      end
    end

    // Bus writes are applied after counting so they win over a one-shot
    // clear, while a wrap still picks up the shadow value held before the write.
    if (wr) begin
      case (offset)
        REG_MAX: begin
          max_sh_n = wdata[WIDTH-1:0];
          if (!ctrl.en) max_act_n = wdata[WIDTH-1:0];
        end
        REG_THR: begin
          thr_sh_n = wdata[WIDTH-1:0];
          if (!ctrl.en) thr_act_n = wdata[WIDTH-1:0];
        end
        REG_CTRL: begin
          ctrl_n.en      = wdata[CTRL_EN];
          ctrl_n.inv     = wdata[CTRL_INV];
          ctrl_n.oneshot = wdata[CTRL_ONESHOT];
          ctrl_n.psc     = wdata[CTRL_PSC_HI:CTRL_PSC_LO];
          done_n         = 1'b0;
          if (wdata[CTRL_EN] != ctrl.en) begin
            max_act_n = max_sh;
            thr_act_n = thr_sh;
            if (wdata[CTRL_EN]) begin
              cnt_n = '0;
              pre_n = '0;
            end
          end
        end
        default: ;
      endcase
    end

    pwm_n = ctrl_n.en ? ((cnt_n < thr_act_n) ^ ctrl_n.inv) : ~ctrl_n.inv;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      max_sh  <= MAX_RST[WIDTH-1:0];
      thr_sh  <= THR_RST[WIDTH-1:0];
      max_act <= MAX_RST[WIDTH-1:0];
      thr_act <= THR_RST[WIDTH-1:0];
      cnt     <= '0;
      pre     <= '0;
      ctrl    <= '0;
      done    <= 1'b0;
      pwm     <= 1'b1;
      pend    <= 1'b0;
    end else begin
      max_sh  <= max_sh_n;
      thr_sh  <= thr_sh_n;
      max_act <= max_act_n;
      thr_act <= thr_act_n;
      cnt     <= cnt_n;
      pre     <= pre_n;
      ctrl    <= ctrl_n;
      done    <= done_n;
      pwm     <= pwm_n;
      pend    <= wrap;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      REG_MAX:  rdata[WIDTH-1:0] = max_sh;
      REG_THR:  rdata[WIDTH-1:0] = thr_sh;
      REG_CTRL: rdata = {ctrl.psc, 5'b0, ctrl.oneshot, ctrl.inv, ctrl.en};
      REG_STAT: rdata = {14'b0, done, ctrl.en};
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: decodes the channel from the byte address,
// instantiates one channel per slot and muxes the readback.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 5
) (
  input  logic                clock,
  input  logic                reset,
  pwm_multi_if.slave          bus,
  output logic [CHANNELS-1:0] PWM_output,
  output logic [CHANNELS-1:0] period_end
);

  localparam int CH_W = ADDR_W - 3;

  logic [CH_W-1:0] ch;
  logic [2:0]      offset;
  logic [15:0]     rd [CHANNELS];

  assign ch     = bus.address[ADDR_W-1:3];
  assign offset = bus.address[2:0];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    assign wr = bus.pwmCtrl && bus.write_enable && (ch == CH_W'(i));

    pwm_multi_channel #(.WIDTH(WIDTH)) u_channel (
      .clock  (clock),
      .reset  (reset),
      .wr     (wr),
      .offset (offset),
      .wdata  (bus.write_data_in),
      .rdata  (rd[i]),
      .pwm    (PWM_output[i]),
      .pend   (period_end[i])
    );
  end

  // Unmatched channel numbers fall through to zero.
  always_comb begin
    bus.read_data_out = '0;
    if (bus.pwmCtrl) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch == CH_W'(i)) bus.read_data_out = rd[i];
      end
    end
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM peripheral for the Minisys-1A MMIO space; successor to the single-channel 16-bit PWM.
- CHANNELS independent channels, each with its own counter, prescaler, double-buffered period/compare registers, output polarity and one-shot mode.
- Sits on the CPU I/O bus behind the PWM chip-select, with register readback.
- Counting continues during bus writes.

Parameters:
CHANNELS, 4, number of PWM channels (1..8)
WIDTH, 16, counter/period/compare width; bus data is 16 bits, so WIDTH <= 16
ADDR_W, 5, byte-address width = 3 + clog2(CHANNELS); 5 covers 4 channels

Ports:
clock  in  1  system clock; all state updates on negedge, as in the rest of the I/O subsystem
reset  in  1  asynchronous, active-low reset
pwmCtrl  in  1  chip select; gates bus access only and does not reset channels
write_enable  in  1  bus write strobe, qualified by pwmCtrl
address  in  ADDR_W  byte address: [ADDR_W-1:3] = channel, [2:0] = register offset
write_data_in  in  16  write data
read_data_out  out  16  combinational readback; 0 when pwmCtrl=0
PWM_output  out  CHANNELS  registered per-channel waveform
period_end  out  CHANNELS  one-clock pulse per channel at counter wrap

Behaviour:
Per-channel registers:
- Offset 0 MAX: shadow period, reset 0xFFFF.
- Offset 2 THR: shadow compare, reset 0x8000.
- Offset 4 CTRL, reset 0x0000:
  - [0] EN
  - [1] INV
  - [2] ONESHOT
  - [15:8] PSC
  - other bits read 0
- Offset 6 STATUS, read-only: [0] running, [1] DONE (sticky), [15:2] 0.
- Writes to offset 6 or to channels >= CHANNELS are ignored; reads of them return 0.
- Bus values are truncated to WIDTH bits; reads are zero-extended.

Reset (reset=0, async):
- All registers take their reset values; active MAX/THR load from the shadow reset values.
- Counter = 0, prescaler = 0, DONE = 0.
- PWM_output = all 1, period_end = 0.

Prescaler and counting:
- The prescaler counts 0..PSC; a tick occurs on the clock where it equals PSC, then it clears. PSC=0 ticks every clock.
- On a tick with EN=1:
  - If counter == MAX_active: counter -> 0, MAX_active/THR_active <= shadows, period_end pulses for that clock.
  - Otherwise counter += 1.

Output:
- Registered every clock from the new counter and new THR_active: raw = (counter < THR_active); PWM_output = raw XOR INV.
- THR=0 gives 0% duty; THR > MAX gives 100% duty.
- Duty = THR/(MAX+1) high ticks per period.
- Period = (MAX+1)*(PSC+1) clocks.
- Disabled channel: counter and prescaler frozen; PWM_output = 1 XOR INV (idle).

Enabling:
- A CTRL write with EN 0->1 in the same clock clears counter and prescaler, loads shadows into active, and sets running.
- The first output cycle has raw = (0 < THR).

Writes while enabled:
- MAX/THR writes reach only the shadows and take effect at the next wrap. This gives glitch-free updates.
- INV, PSC and ONESHOT take effect the clock after the write.
- EN 1->0 writes stop the channel immediately and load shadows into active.
- When disabled, MAX/THR writes load shadow and active together.

One-shot:
- ONESHOT=1: at the first wrap the channel clears EN in hardware, sets DONE, pulses period_end and goes idle.
- DONE clears on any CTRL write to that channel.

Simultaneous events:
- A bus write and a wrap on the same clock: the bus value goes to the shadow, and the wrap loads the old shadow.
- A bus write to CTRL and a one-shot clear on the same clock: the bus write wins.

Boundaries:
- MAX=0: period of 1 tick, wraps every tick, period_end on every tick.
- MAX=2^WIDTH-1 wraps to 0 without overflow.

Decomposition:
- Shared header pwm_defs.vh holds:
  - register offsets (PWM_MAX=0, PWM_THR=2, PWM_CTRL=4, PWM_STAT=6)
  - CTRL bit indices (EN=0, INV=1, ONESHOT=2, PSC_LO=8, PSC_HI=15)
  - reset values (0xFFFF, 0x8000)
- Sub-module pwm_channel: one channel's registers, prescaler, counter, shadows and output. It has a per-channel write strobe and readback.
- pwm_multi decodes the address, generates CHANNELS instances and muxes readback.

Test Plan:
- Reset then no writes: PWM_output=all 1, read CTRL=0x0000, MAX=0xFFFF, THR=0x8000, period_end=0.
- ch0: MAX=9, THR=3, CTRL=0x0001 -> PWM_output[0] high 3 clocks, low 7, period 10; period_end[0] every 10th clock; ch1..3 idle high.
- ch1: MAX=4, THR=2, CTRL=0x0301 (PSC=3, EN) -> period 20 clocks, high 8, low 12; then write INV (CTRL=0x0303) -> waveform inverted the next clock.
- ch0 running with MAX=9, THR=3; write THR=7 mid-period -> current period keeps 3-high; from the next wrap onward 7-high/3-low. THR=0 gives constant low; THR=10 gives constant high.
- ch2: MAX=5, THR=2, CTRL=0x0005 (ONESHOT) -> exactly one 6-clock period with a single period_end[2]; then EN reads 0, STATUS=0x0002, output idle high; a CTRL write clears DONE.
- ch3 mid-period, assert reset=0 asynchronously between edges -> outputs go to 1 immediately; after release all registers are at reset values and the channel is disabled. Also check that pwmCtrl=0 with write_enable=1 changes nothing and read_data_out=0.
